// File: rtl/uart_pkg.sv
// Shared UART RX constants and capture FSM state type.
// Imported by the FIFO storage and the uart_rx_fifo top.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_ACK  = 1'b1
  } cap_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: DEPTH x 8, synchronous write, asynchronous read.
// Contents are not reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [UART_DATA_W-1:0] rdata
);

  logic [UART_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: capture handshake, FWFT queue, overrun flag.
// Define UART_RX_FIFO_IRQ_EN to enable the fill-level/overrun irq.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int IRQ_LEVEL = 8
) (
  input  logic                     clk,
  input  logic                     resetq,
  input  logic                     uart_valid,
  input  logic [UART_DATA_W-1:0]   uart_data,
  output logic                     uart_rd,
  input  logic                     rd,
  output logic [UART_DATA_W-1:0]   rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  input  logic                     clr_overrun,
  output logic                     irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  cap_state_e    state_q;
  cap_state_e    state_d;
  logic          cap;
  logic          pop;
  logic          wr;
  logic          drop;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ovr_q;
  logic          ovr_d;

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    unique case (state_q)
      CAP_IDLE: begin
        if (uart_valid) begin
          cap     = 1'b1;
          state_d = CAP_ACK;
        end
      end
      CAP_ACK: begin
        state_d = CAP_IDLE;
      end
      default: begin
        state_d = CAP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q <= CAP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Acknowledge comes straight from the state register.
  assign uart_rd = (state_q == CAP_ACK);

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign overrun = ovr_q;

  assign pop  = rd & ~empty;
  assign wr   = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  always_comb begin
    count_d = count_q;
    unique case ({wr, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_comb begin
    ovr_d = ovr_q;
    if (drop) begin
      ovr_d = 1'b1;
    end else if (clr_overrun) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef UART_RX_FIFO_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (count_d >= CW'(IRQ_LEVEL)) | ovr_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr),
    .waddr (wr_ptr_q),
    .wdata (uart_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

endmodule
